// File: rtl/seg7_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seg7_scan_ctrl
//
// Bus-mapped multi-digit 7-segment scan controller. Holds NUM_DIGITS hex
// nibbles, a per-digit decimal-point mask and a control register, all
// readable and writable over a shared 8-bit tristate data bus. Each digit
// slot is split into 8 sub-phases of SCAN_DIV cycles. Sub-phase 0 is always
// a blank anti-ghosting gap, and the remaining phases give duty-cycle
// brightness.
//
// Register window (H = NUM_DIGITS/2, offsets from BASE_ADDR):
//   0..H-1 : DATAk  [7:4] = digit 2k, [3:0] = digit 2k+1   (reset 8'h00)
//   H      : DOT    bit i = decimal point of digit i       (reset 8'h00)
//   H+1    : CTRL   [0] ENABLE, [3:1] BRIGHT               (reset 8'h0F)
//
// Optional feature macro: SEG7_BRIGHTNESS_EN
//   defined   : BRIGHT is stored, and a digit is lit while 1 <= SUB <= BRIGHT.
//   undefined : BRIGHT is not stored, CTRL[3:1] reads 0, the duty is fixed
//               at 7/8 and CTRL resets to 8'h01.
//
// Ports:
//   clk_i         system clock, rising edge
//   rst_ni        asynchronous active-low reset
//   bus_we_i      1 = write cycle, 0 = read cycle
//   bus_addr_i    bus address
//   bus_data_io   shared tristate data bus
//   seg_select_o  digit anodes, active-low one-hot, bit 0 = leftmost digit
//   dec_out_o     segments, active-low, [6:0] = g..a, [7] = decimal point
// ---------------------------------------------------------------------------
module seg7_scan_ctrl #(
  parameter logic [7:0] BASE_ADDR  = 8'hD0,
  parameter int         NUM_DIGITS = 4,
  parameter int         SCAN_DIV   = 6250
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  bus_we_i,
  input  logic [7:0]            bus_addr_i,
  inout  wire  [7:0]            bus_data_io,
  output logic [NUM_DIGITS-1:0] seg_select_o,
  output logic [7:0]            dec_out_o
);

  localparam int         HALF     = NUM_DIGITS / 2;
  localparam int         DW       = $clog2(NUM_DIGITS);
  localparam int         PW       = $clog2(SCAN_DIV);
  localparam logic [7:0] DOT_OFS  = 8'(HALF);
  localparam logic [7:0] CTRL_OFS = 8'(HALF + 1);

  // Scan state
  logic [PW-1:0] prescale_q;
  logic [2:0]    scanSub_q;
  logic [DW-1:0] digitIdx_q;

  // Bus-visible registers
  logic [3:0]            nibble_q [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] dotMask_q;
  logic                  enable_q;
`ifdef SEG7_BRIGHTNESS_EN
  logic [2:0]            bright_q;
`endif

  // Read-back path
  logic       txEn_q;
  logic [7:0] txData_q;

  // Registered display outputs
  logic [NUM_DIGITS-1:0] segSel_q;
  logic [7:0]            decOut_q;

  // Combinational helpers
  logic [7:0]            addrOfs;
  logic                  hitData;
  logic                  hitDot;
  logic                  hitCtrl;
  logic                  anyHit;
  logic                  scanTick;
  logic                  scanOn;
  logic [7:0]            readData;
  logic [NUM_DIGITS-1:0] selLow;
  logic [6:0]            glyph;

  // Standard active-low hex glyphs, bit order g..a.
  function automatic logic [6:0] hexGlyph(input logic [3:0] n);
    logic [6:0] g;
    case (n)
      4'h0: g = 7'h40;
      4'h1: g = 7'h79;
      4'h2: g = 7'h24;
      4'h3: g = 7'h30;
      4'h4: g = 7'h19;
      4'h5: g = 7'h12;
      4'h6: g = 7'h02;
      4'h7: g = 7'h78;
      4'h8: g = 7'h00;
      4'h9: g = 7'h10;
      4'hA: g = 7'h08;
      4'hB: g = 7'h03;
      4'hC: g = 7'h46;
      4'hD: g = 7'h21;
      4'hE: g = 7'h06;
      default: g = 7'h0E;
    endcase
    return g;
  endfunction

  // Offset arithmetic wraps mod 256, so addresses below BASE_ADDR land far
  // outside the small window and never hit.
  assign addrOfs  = bus_addr_i - BASE_ADDR;
  assign hitData  = (addrOfs < DOT_OFS);
  assign hitDot   = (addrOfs == DOT_OFS);
  assign hitCtrl  = (addrOfs == CTRL_OFS);
  assign anyHit   = hitData | hitDot | hitCtrl;
  assign scanTick = (prescale_q == PW'(SCAN_DIV - 1));

  // Read mux: assembles the byte the bus would see for the current address.
  always_comb begin
    readData = 8'h00;
    for (int k = 0; k < HALF; k++) begin
      if (addrOfs == 8'(k)) begin
        readData = {nibble_q[2*k], nibble_q[2*k+1]};
      end
    end
    if (hitDot) begin
      readData = 8'(dotMask_q);
    end
    if (hitCtrl) begin
`ifdef SEG7_BRIGHTNESS_EN
      readData = {4'b0000, bright_q, enable_q};
`else
      readData = {7'b0000000, enable_q};
`endif
    end
  end

  // Lit decision and per-digit drive values, registered below.
  always_comb begin
`ifdef SEG7_BRIGHTNESS_EN
    scanOn = enable_q && (scanSub_q != 3'd0) && (scanSub_q <= bright_q);
`else
    scanOn = enable_q && (scanSub_q != 3'd0);
`endif
    selLow = ~(NUM_DIGITS'(1) << digitIdx_q);
    glyph  = hexGlyph(nibble_q[digitIdx_q]);
  end

  // Prescaler, sub-phase and digit counters. They keep running while the
  // display is disabled so re-enabling resumes at the same scan position.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prescale_q <= '0;
      scanSub_q  <= 3'd0;
      digitIdx_q <= '0;
    end else if (scanTick) begin
      prescale_q <= '0;
      scanSub_q  <= scanSub_q + 3'd1;
      if (scanSub_q == 3'd7) begin
        if (digitIdx_q == DW'(NUM_DIGITS - 1)) begin
          digitIdx_q <= '0;
        end else begin
          digitIdx_q <= digitIdx_q + DW'(1);
        end
      end
    end else begin
      prescale_q <= prescale_q + PW'(1);
    end
  end

  // Register writes. Reserved bits are simply not stored.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        nibble_q[i] <= 4'h0;
      end
      dotMask_q <= '0;
      enable_q  <= 1'b1;
`ifdef SEG7_BRIGHTNESS_EN
      bright_q  <= 3'd7;
`endif
    end else if (bus_we_i) begin
      for (int k = 0; k < HALF; k++) begin
        if (addrOfs == 8'(k)) begin
          nibble_q[2*k]   <= bus_data_io[7:4];
          nibble_q[2*k+1] <= bus_data_io[3:0];
        end
      end
      if (hitDot) begin
        dotMask_q <= bus_data_io[NUM_DIGITS-1:0];
      end
      if (hitCtrl) begin
        enable_q <= bus_data_io[0];
`ifdef SEG7_BRIGHTNESS_EN
        bright_q <= bus_data_io[3:1];
`endif
      end
    end
  end

  // Read-back: a hit during a read cycle arms the transmit flag for the next
  // cycle. Data is captured alongside so the bus sees a stable byte.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      txEn_q   <= 1'b0;
      txData_q <= 8'h00;
    end else begin
      txEn_q   <= !bus_we_i && anyHit;
      txData_q <= readData;
    end
  end

  // The flag is one cycle old, so also gate on the live write strobe to keep
  // off the bus whenever the processor is driving it.
  assign bus_data_io = (txEn_q && !bus_we_i) ? txData_q : 8'bzzzz_zzzz;

  // Registered display outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      segSel_q <= '1;
      decOut_q <= 8'hFF;
    end else if (scanOn) begin
      segSel_q <= selLow;
      decOut_q <= {~dotMask_q[digitIdx_q], glyph};
    end else begin
      segSel_q <= '1;
      decOut_q <= 8'hFF;
    end
  end

  assign seg_select_o = segSel_q;
  assign dec_out_o    = decOut_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seg7_scan_ctrl
//
// Directed bench for seg7_scan_ctrl with SCAN_DIV=2 and NUM_DIGITS=4, so a
// sub-phase lasts 2 cycles, a digit slot 16 cycles and a frame 64 cycles.
// "cyc" counts rising edges since reset release. The value sampled after edge
// c reflects scan state n = c-1: sub = (n/2)%8, digit = (n/16)%4.
// The data bus has a pull-up, so an undriven bus reads as 8'hFF. No register
// value read here is 8'hFF.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_seg7_scan_ctrl;

`ifdef SEG7_BRIGHTNESS_EN
  localparam bit         BRIGHT_EN = 1'b1;
  localparam logic [7:0] CTRL_RST  = 8'h0F;
  localparam logic [7:0] CTRL_07RD = 8'h07;
`else
  localparam bit         BRIGHT_EN = 1'b0;
  localparam logic [7:0] CTRL_RST  = 8'h01;
  localparam logic [7:0] CTRL_07RD = 8'h01;
`endif

  logic       clk;
  logic       rstN;
  logic       busWe;
  logic [7:0] busAddr;
  logic [7:0] tbData;
  logic       tbDrive;
  wire  [7:0] busData;
  logic [3:0] segSel;
  logic [7:0] decOut;

  int cyc;
  int checkCount;
  int passCount;

  assign busData = tbDrive ? tbData : 8'bzzzz_zzzz;

  for (genvar i = 0; i < 8; i++) begin : g_pull
    pullup (busData[i]);
  end

  seg7_scan_ctrl #(
    .BASE_ADDR (8'hD0),
    .NUM_DIGITS(4),
    .SCAN_DIV  (2)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rstN),
    .bus_we_i    (busWe),
    .bus_addr_i  (busAddr),
    .bus_data_io (busData),
    .seg_select_o(segSel),
    .dec_out_o   (decOut)
  );

  // 100 MHz clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net in case the sequence below ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected sequence end");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end else begin
      passCount++;
    end
  endtask

  task automatic checkScan(input string tag, input logic [3:0] expSel,
                           input logic [7:0] expDec);
    checkOutput({tag, ".sel"}, 32'(segSel), 32'(expSel));
    checkOutput({tag, ".dec"}, 32'(decOut), 32'(expDec));
  endtask

  task automatic applyStimulus(input logic we, input logic [7:0] addr,
                               input logic [7:0] data, input logic drive);
    busWe   = we;
    busAddr = addr;
    tbData  = data;
    tbDrive = drive;
  endtask

  // Advance one rising edge and sample 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic waitUntil(input int target);
    while (cyc < target) tick();
  endtask

  task automatic busWrite(input logic [7:0] addr, input logic [7:0] data);
    applyStimulus(1'b1, addr, data, 1'b1);
    tick();
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0);
  endtask

  initial begin
    checkCount = 0;
    passCount  = 0;
    cyc        = 0;
    rstN       = 1'b0;
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0);

    // Power-up reset
    tick();
    tick();
    checkScan("rst", 4'hF, 8'hFF);
    checkOutput("rst.bus", 32'(busData), 32'hFF);
    rstN = 1'b1;
    cyc  = 0;

    // First blank gap, then digit 0 shows "0"
    tick();
    checkScan("gap1", 4'hF, 8'hFF);
    tick();
    checkScan("gap2", 4'hF, 8'hFF);
    tick();
    checkScan("first", 4'hE, 8'hC0);

    // Load digits 1,2,A,F with the dot on digit 1
    busWrite(8'hD0, 8'h12);
    busWrite(8'hD1, 8'hAF);
    busWrite(8'hD2, 8'h02);
    waitUntil(8);
    checkScan("dig0", 4'hE, 8'hF9);
    waitUntil(20);
    checkScan("dig1", 4'hD, 8'h24);
    waitUntil(40);
    checkScan("dig2", 4'hB, 8'h88);
    waitUntil(49);
    checkScan("gapD3", 4'hF, 8'hFF);
    waitUntil(55);
    checkScan("dig3", 4'h7, 8'h8E);
    waitUntil(70);
    checkScan("wrap", 4'hE, 8'hF9);

    // BRIGHT=3 on the digit-1 slot spanning c=81..96
    waitUntil(78);
    busWrite(8'hD3, 8'h07);
    waitUntil(81);
    checkScan("brGap", 4'hF, 8'hFF);
    waitUntil(83);
    checkScan("brOn1", 4'hD, 8'h24);
    waitUntil(88);
    checkScan("brOn3", 4'hD, 8'h24);
    waitUntil(89);
    checkScan("brOff4", BRIGHT_EN ? 4'hF : 4'hD, BRIGHT_EN ? 8'hFF : 8'h24);
    waitUntil(96);
    checkScan("brOff7", BRIGHT_EN ? 4'hF : 4'hD, BRIGHT_EN ? 8'hFF : 8'h24);

    // Read-back
    waitUntil(97);
    applyStimulus(1'b0, 8'hD1, 8'h00, 1'b0);
    tick();
    checkOutput("rdD1", 32'(busData), 32'hAF);
    applyStimulus(1'b0, 8'hD2, 8'h00, 1'b0);
    tick();
    checkOutput("rdDot", 32'(busData), 32'h02);
    applyStimulus(1'b0, 8'hD3, 8'h00, 1'b0);
    tick();
    checkOutput("rdCtrl", 32'(busData), 32'(CTRL_07RD));
    applyStimulus(1'b0, 8'hD4, 8'h00, 1'b0);
    tick();
    checkOutput("rdUnmapped", 32'(busData), 32'hFF);
    applyStimulus(1'b0, 8'hD1, 8'h00, 1'b0);
    tick();
    checkOutput("rdD1again", 32'(busData), 32'hAF);
    applyStimulus(1'b1, 8'hD5, 8'h00, 1'b0);
    #1;
    checkOutput("busDuringWe", 32'(busData), 32'hFF);
    tick();
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0);

    // ENABLE off mid-slot on digit 3, then back on at the same position
    waitUntil(104);
    busWrite(8'hD3, 8'h0F);
    waitUntil(116);
    busWrite(8'hD3, 8'h0E);
    checkScan("enStill", 4'h7, 8'h8E);
    tick();
    checkScan("enOff", 4'hF, 8'hFF);
    busWrite(8'hD3, 8'h0F);
    checkScan("enOffHold", 4'hF, 8'hFF);
    tick();
    checkScan("enBack", 4'h7, 8'h8E);
    waitUntil(129);
    checkScan("enGap", 4'hF, 8'hFF);
    waitUntil(131);
    checkScan("enNext", 4'hE, 8'hF9);

    // BRIGHT=0 gives a dark frame
    waitUntil(132);
    busWrite(8'hD3, 8'h01);
    waitUntil(140);
    checkScan("dark0", BRIGHT_EN ? 4'hF : 4'hE, BRIGHT_EN ? 8'hFF : 8'hF9);
    waitUntil(160);
    checkScan("dark1", BRIGHT_EN ? 4'hF : 4'hD, BRIGHT_EN ? 8'hFF : 8'h24);
    busWrite(8'hD3, 8'h0F);

    // Reset mid-slot during a read
    waitUntil(170);
    applyStimulus(1'b0, 8'hD1, 8'h00, 1'b0);
    tick();
    checkOutput("preRstBus", 32'(busData), 32'hAF);
    checkScan("preRst", 4'hB, 8'h88);
    #2;
    rstN = 1'b0;
    #1;
    checkScan("asyncRst", 4'hF, 8'hFF);
    checkOutput("asyncRstBus", 32'(busData), 32'hFF);
    tick();
    tick();
    rstN = 1'b1;
    cyc  = 0;
    applyStimulus(1'b0, 8'hD0, 8'h00, 1'b0);
    tick();
    checkOutput("rstD0", 32'(busData), 32'h00);
    checkScan("rstGap", 4'hF, 8'hFF);
    applyStimulus(1'b0, 8'hD1, 8'h00, 1'b0);
    tick();
    checkOutput("rstD1", 32'(busData), 32'h00);
    applyStimulus(1'b0, 8'hD2, 8'h00, 1'b0);
    tick();
    checkOutput("rstDot", 32'(busData), 32'h00);
    checkScan("rstFirst", 4'hE, 8'hC0);
    applyStimulus(1'b0, 8'hD3, 8'h00, 1'b0);
    tick();
    checkOutput("rstCtrl", 32'(busData), 32'(CTRL_RST));
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0);
    tick();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
